// File: rtl/rot_serializer.sv
// rot_serializer: buffers words from the rotate stage in a 2-entry FIFO and
// shifts each one out LSB first on an idle-high, framed serial line with
// DIV clock cycles per bit and GAP idle bit periods after each word.
// Optional feature: define ROT_SER_PARITY_EN to append one even-parity bit
// after the MSB of every frame.
module rot_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             ser_tick,
  output logic             busy,
  output logic             ovf
);

`ifdef ROT_SER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int BIT_W   = $clog2(NBITS + 1);
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_CYC = GAP * DIV;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAPW} state_t;

  state_t state, state_n;

  // FIFO storage and bookkeeping
  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count, count_n;
  logic             push, pop;
  logic [NBITS-1:0] load_word;

  // Serializer datapath
  logic [NBITS-1:0] sh, sh_n;
  logic [BIT_W-1:0] bit_cnt, bit_n;
  logic [DIV_W-1:0] div_cnt, div_n;
  logic [GAP_W-1:0] gap_cnt, gap_n;
  logic             out_n, frame_n, tick_n, busy_n, ovf_n;

  // Ready depends only on the registered count, so a pop in the same cycle
  // never opens a full buffer and there is no in_valid->in_ready path.
  assign in_ready = (count < 2'd2);
  assign push     = in_valid & in_ready;

`ifdef ROT_SER_PARITY_EN
  assign load_word = {^mem[rd_ptr], mem[rd_ptr]};
`else
  assign load_word = mem[rd_ptr];
`endif

  // Occupancy update: simultaneous push and pop leave the count unchanged
  always_comb begin
    case ({push, pop})
      2'b10:   count_n = count + 2'd1;
      2'b01:   count_n = count - 2'd1;
      default: count_n = count;
    endcase
  end

  // FIFO pointers and count
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; blocking here would create order-dependent races.
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count_n;
    end
  end

  // FIFO payload write
  // NOTE: the storage array is deliberately not reset; the pointers and count
  // decide validity, and leaving data unreset keeps it plain RAM-style flops.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Next-state and next-output decode for the serializer FSM
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_n = state;
    sh_n    = sh;
    bit_n   = bit_cnt;
    div_n   = div_cnt;
    gap_n   = gap_cnt;
    out_n   = ser_out;
    frame_n = ser_frame;
    tick_n  = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        out_n   = 1'b1;
        frame_n = 1'b0;
        if (count != 2'd0) begin
          pop     = 1'b1;
          sh_n    = load_word;
          bit_n   = '0;
          div_n   = '0;
          out_n   = load_word[0];
          frame_n = 1'b1;
          tick_n  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (bit_cnt == BIT_LAST) begin
            out_n   = 1'b1;
            frame_n = 1'b0;
            gap_n   = '0;
            state_n = (GAP == 0) ? IDLE : GAPW;
          end else begin
            // Rotate rather than shift; only bit 0 is ever driven out.
            sh_n   = {sh[0], sh[NBITS-1:1]};
            bit_n  = bit_cnt + 1'b1;
            out_n  = sh[1];
            tick_n = 1'b1;
          end
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      GAPW: begin
        out_n   = 1'b1;
        frame_n = 1'b0;
        if (gap_cnt == GAP_LAST) state_n = IDLE;
        else                     gap_n   = gap_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE) || (count_n != 2'd0);
    ovf_n  = ovf | (in_valid & ~in_ready);
  end

  // FSM state register
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_n;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      sh        <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      ser_out   <= 1'b1;
      ser_frame <= 1'b0;
      ser_tick  <= 1'b0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      sh        <= sh_n;
      bit_cnt   <= bit_n;
      div_cnt   <= div_n;
      gap_cnt   <= gap_n;
      ser_out   <= out_n;
      ser_frame <= frame_n;
      ser_tick  <= tick_n;
      busy      <= busy_n;
      ovf       <= ovf_n;
    end
  end

endmodule

// File: tb/tb_rot_serializer.sv
// Testbench for rot_serializer: one instance with DIV=4/GAP=1 and one with
// DIV=1/GAP=0. A line monitor decodes every frame from the pins and compares
// the word against a queue of accepted words.
module tb_rot_serializer;

  localparam int WIDTH = 8;
  localparam int DIV_A = 4;
  localparam int GAP_A = 1;
  localparam int DIV_B = 1;
  localparam int GAP_B = 0;
`ifdef ROT_SER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  logic             clk;
  logic             clear;
  logic [WIDTH-1:0] a_data, b_data;
  logic             a_valid, b_valid;
  logic             a_ready, b_ready;
  logic             a_out, a_frame, a_tick, a_busy, a_ovf;
  logic             b_out, b_frame, b_tick, b_busy, b_ovf;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q0[$];
  logic [WIDTH-1:0] exp_q1[$];

  // Monitor state, per instance
  bit               in_fr[2];
  bit               have_prev[2];
  int               fcyc[2], idle_cnt[2], frames[2], last_len[2], last_gap[2];
  logic             last_par[2];
  logic [NBITS-1:0] acc[2];
  logic             cur_bit[2];
  logic             m_fr, m_out, m_tk;
  int               m_div, m_gap, m_pos, m_idx;

  rot_serializer #(.WIDTH(WIDTH), .DIV(DIV_A), .GAP(GAP_A)) dut_a (
    .clk(clk), .clear(clear), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .ser_out(a_out), .ser_frame(a_frame),
    .ser_tick(a_tick), .busy(a_busy), .ovf(a_ovf)
  );

  rot_serializer #(.WIDTH(WIDTH), .DIV(DIV_B), .GAP(GAP_B)) dut_b (
    .clk(clk), .clear(clear), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .ser_out(b_out), .ser_frame(b_frame),
    .ser_tick(b_tick), .busy(b_busy), .ovf(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame end: the decoded word must be the oldest accepted one
  task automatic frame_end(input int k);
    logic [WIDTH-1:0] got, exp;
    got = acc[k][WIDTH-1:0];
`ifdef ROT_SER_PARITY_EN
    checks++;
    if (acc[k][NBITS-1] !== ^got) begin
      errors++;
      $display("FAIL parity_bit[%0d]: got %b, need %b for word %h", k, acc[k][NBITS-1], ^got, got);
    end
`endif
    checks++;
    if (k == 0 && exp_q0.size() > 0)      exp = exp_q0.pop_front();
    else if (k == 1 && exp_q1.size() > 0) exp = exp_q1.pop_front();
    else begin
      errors++;
      $display("FAIL unexpected_frame[%0d]: got word %h, nothing pending", k, got);
      return;
    end
    if (got !== exp) begin
      errors++;
      $display("FAIL frame_word[%0d]: got %h, need %h", k, got, exp);
    end
  endtask

  // Line monitor: bit timing, tick placement, idle level, frame length, gaps
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_fr  = (k == 0) ? a_frame : b_frame;
      m_out = (k == 0) ? a_out   : b_out;
      m_tk  = (k == 0) ? a_tick  : b_tick;
      m_div = (k == 0) ? DIV_A : DIV_B;
      m_gap = (k == 0) ? GAP_A * DIV_A + 1 : GAP_B * DIV_B + 1;
      if (!clear) begin
        in_fr[k]     = 1'b0;
        have_prev[k] = 1'b0;
        idle_cnt[k]  = 0;
      end else if (m_fr) begin
        if (!in_fr[k]) begin
          in_fr[k] = 1'b1;
          fcyc[k]  = 0;
          acc[k]   = '0;
          if (have_prev[k]) begin
            last_gap[k] = idle_cnt[k];
            checks++;
            if (idle_cnt[k] < m_gap) begin
              errors++;
              $display("FAIL gap_min[%0d]: got %0d idle cycles, need >= %0d", k, idle_cnt[k], m_gap);
            end
          end
        end
        m_pos = fcyc[k] % m_div;
        m_idx = fcyc[k] / m_div;
        checks++;
        if (m_tk !== (m_pos == 0)) begin
          errors++;
          $display("FAIL tick_place[%0d]: got %b at framed cycle %0d, need %b", k, m_tk, fcyc[k], m_pos == 0);
        end
        if (m_pos == 0) begin
          if (m_idx < NBITS) acc[k][m_idx] = m_out;
          cur_bit[k] = m_out;
        end else begin
          checks++;
          if (m_out !== cur_bit[k]) begin
            errors++;
            $display("FAIL bit_hold[%0d]: got %b at framed cycle %0d, need %b", k, m_out, fcyc[k], cur_bit[k]);
          end
        end
        fcyc[k]++;
      end else begin
        checks++;
        if (m_out !== 1'b1 || m_tk !== 1'b0) begin
          errors++;
          $display("FAIL idle_line[%0d]: got out=%b tick=%b, need out=1 tick=0", k, m_out, m_tk);
        end
        if (in_fr[k]) begin
          in_fr[k]     = 1'b0;
          have_prev[k] = 1'b1;
          idle_cnt[k]  = 1;
          last_len[k]  = fcyc[k];
          last_par[k]  = acc[k][NBITS-1];
          checks++;
          if (fcyc[k] != NBITS * m_div) begin
            errors++;
            $display("FAIL frame_len[%0d]: got %0d cycles, need %0d", k, fcyc[k], NBITS * m_div);
          end
          frame_end(k);
          frames[k]++;
        end else begin
          idle_cnt[k]++;
        end
      end
    end
  end

  task automatic push_a(input logic [WIDTH-1:0] w);
    int g = 0;
    while (a_ready !== 1'b1 && g < 5000) begin @(negedge clk); g++; end
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL push_a_timeout: ready=%b, need 1", a_ready); end
    a_data = w; a_valid = 1'b1; exp_q0.push_back(w);
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic push_b(input logic [WIDTH-1:0] w);
    int g = 0;
    while (b_ready !== 1'b1 && g < 5000) begin @(negedge clk); g++; end
    checks++;
    if (b_ready !== 1'b1) begin errors++; $display("FAIL push_b_timeout: ready=%b, need 1", b_ready); end
    b_data = w; b_valid = 1'b1; exp_q1.push_back(w);
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic wait_frames(input int k, input int target, input int budget);
    int g = 0;
    while (frames[k] < target && g < budget) begin @(negedge clk); g++; end
    checks++;
    if (frames[k] < target) begin
      errors++;
      $display("FAIL frames_timeout[%0d]: got %0d frames, need %0d", k, frames[k], target);
    end
  endtask

  task automatic wait_idle(input int budget);
    int g = 0;
    while ((a_busy !== 1'b0 || b_busy !== 1'b0) && g < budget) begin @(negedge clk); g++; end
    checks++;
    if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: got busy a=%b b=%b, need 0", a_busy, b_busy);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    clear = 1'b0;
    exp_q0.delete(); exp_q1.delete();
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear = 1'b1;
    #1 clear = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_out, a_frame, a_tick, a_busy, a_ovf} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_a: got out/frame/tick/busy/ovf=%b, need 10000", {a_out, a_frame, a_tick, a_busy, a_ovf});
    end
    checks++;
    if ({b_out, b_frame, b_tick, b_busy, b_ovf} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_b: got out/frame/tick/busy/ovf=%b, need 10000", {b_out, b_frame, b_tick, b_busy, b_ovf});
    end
    clear = 1'b1;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got a=%b b=%b, need 1", a_ready, b_ready);
    end
  endtask

  task automatic test_frame();
    int n = 0, t = 0, g = 0;
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL frame_ready: got %b, need 1", a_ready); end
    a_data = 8'hA5; a_valid = 1'b1; exp_q0.push_back(8'hA5);
    @(negedge clk);
    a_valid = 1'b0;
    checks++;
    if (a_frame !== 1'b0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL frame_latency: got frame=%b busy=%b after push, need 0/1", a_frame, a_busy);
    end
    @(negedge clk);
    checks++;
    if ({a_frame, a_out, a_tick} !== 3'b111) begin
      errors++;
      $display("FAIL frame_first_bit: got frame/out/tick=%b, need 111", {a_frame, a_out, a_tick});
    end
    while (a_frame === 1'b1 && n < 1000) begin
      n++;
      if (a_tick === 1'b1) t++;
      @(negedge clk);
    end
    checks++;
    if (n != NBITS * DIV_A || t != NBITS) begin
      errors++;
      $display("FAIL frame_span: got %0d cycles %0d ticks, need %0d cycles %0d ticks", n, t, NBITS * DIV_A, NBITS);
    end
    while (a_busy === 1'b1 && a_frame === 1'b0 && g < 100) begin g++; @(negedge clk); end
    checks++;
    if (g != GAP_A * DIV_A || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_gap: got %0d gap cycles busy=%b, need %0d and 0", g, a_busy, GAP_A * DIV_A);
    end
  endtask

  task automatic test_reset_mid_frame();
    int seen = 0;
    a_data = 8'hA5; a_valid = 1'b1; exp_q0.push_back(8'hA5);
    @(negedge clk);
    a_valid = 1'b0;
    repeat (1 + 3 * DIV_A + 1) @(negedge clk);
    checks++;
    if (a_frame !== 1'b1 || a_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_bit3: got frame=%b out=%b, need 1/0", a_frame, a_out);
    end
    #1 clear = 1'b0;
    exp_q0.delete(); exp_q1.delete();
    #1;
    checks++;
    if ({a_out, a_frame, a_tick, a_busy, a_ovf} !== 5'b10000) begin
      errors++;
      $display("FAIL mid_async_reset: got out/frame/tick/busy/ovf=%b, need 10000", {a_out, a_frame, a_tick, a_busy, a_ovf});
    end
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b, need 1", a_ready); end
    for (int i = 0; i < 3 * NBITS * DIV_A; i++) begin
      if (a_frame === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_resume: got %0d framed cycles busy=%b, need 0/0", seen, a_busy);
    end
  endtask

  task automatic test_back_to_back();
    int base = frames[0];
    logic [WIDTH-1:0] words[3];
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (a_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b, need 1", i, a_ready); end
      a_data = words[i]; a_valid = 1'b1; exp_q0.push_back(words[i]);
      @(negedge clk);
    end
    a_valid = 1'b0;
    checks++;
    if (a_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got ready=%b, need 0", a_ready); end
    wait_frames(0, base + 3, 3 * (NBITS * DIV_A + 20));
    checks++;
    if (exp_q0.size() != 0 || last_gap[0] != GAP_A * DIV_A + 1) begin
      errors++;
      $display("FAIL b2b_drain: got %0d pending gap %0d, need 0 pending gap %0d", exp_q0.size(), last_gap[0], GAP_A * DIV_A + 1);
    end
    wait_idle(200);
  endtask

  task automatic test_overflow();
    int base = frames[0];
    push_a(8'h3C);
    push_a(8'hC3);
    push_a(8'h5A);
    checks++;
    if (a_ready !== 1'b0 || a_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pre: got ready=%b ovf=%b, need 0/0", a_ready, a_ovf);
    end
    a_data = 8'hEE; a_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, need 1", a_ovf); end
    @(negedge clk);
    a_valid = 1'b0;
    wait_frames(0, base + 3, 3 * (NBITS * DIV_A + 20));
    wait_idle(200);
    checks++;
    if (a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, need 1", a_ovf); end
    do_clear();
    checks++;
    if (a_ovf !== 1'b0 || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clear: got ovf=%b ready=%b, need 0/1", a_ovf, a_ready);
    end
  endtask

  task automatic test_parity();
    logic [WIDTH-1:0] words[2];
    logic             par[2];
    words[0] = 8'h07; par[0] = 1'b1;
    words[1] = 8'h03; par[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      int base = frames[0];
      push_a(words[i]);
      wait_frames(0, base + 1, NBITS * DIV_A + 20);
`ifdef ROT_SER_PARITY_EN
      checks++;
      if (last_len[0] != (WIDTH + 1) * DIV_A || last_par[0] !== par[i]) begin
        errors++;
        $display("FAIL parity_%h: got len %0d par %b, need %0d and %b", words[i], last_len[0], last_par[0], (WIDTH + 1) * DIV_A, par[i]);
      end
`else
      checks++;
      if (last_len[0] != WIDTH * DIV_A) begin
        errors++;
        $display("FAIL noparity_%h: got len %0d (par flag %b), need %0d", words[i], last_len[0], par[i], WIDTH * DIV_A);
      end
`endif
      wait_idle(200);
    end
  endtask

  task automatic test_gap0();
    int base = frames[1];
    push_b(8'h96);
    push_b(8'h3E);
    wait_frames(1, base + 2, 4 * NBITS + 20);
    checks++;
    if (last_gap[1] != 1 || last_len[1] != NBITS) begin
      errors++;
      $display("FAIL gap0: got gap %0d len %0d, need gap 1 len %0d", last_gap[1], last_len[1], NBITS);
    end
    wait_idle(50);
  endtask

  task automatic test_random();
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(20, 0)) @(negedge clk);
          push_a(WIDTH'($urandom));
        end
      end
      begin
        for (int j = 0; j < 24; j++) begin
          repeat ($urandom_range(6, 0)) @(negedge clk);
          push_b(WIDTH'($urandom));
        end
      end
    join
    wait_idle(12 * (NBITS * DIV_A + 10));
    @(negedge clk);
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0 || a_ovf !== 1'b0 || b_ovf !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: got pending %0d/%0d ovf %b/%b, need 0/0 and 0/0", exp_q0.size(), exp_q1.size(), a_ovf, b_ovf);
    end
  endtask

  initial begin
    a_data = '0; b_data = '0; a_valid = 1'b0; b_valid = 1'b0;
    test_reset();
    test_frame();
    test_reset_mid_frame();
    test_back_to_back();
    test_overflow();
    test_parity();
    test_gap0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
